// File: rtl/sha_pkg.sv
// Shared types and helpers for the SHA result reorder buffer.
// Digest widths, reorder FSM states, words-per-digest helper.
package sha_pkg;

  localparam int SHA1_DIGEST_W   = 160;
  localparam int SHA256_DIGEST_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    SEND
  } rob_state_e;

  function automatic int words_per_digest(input int dw, input int ow);
    return dw / ow;
  endfunction

endpackage

// File: rtl/sha_result_reorder_buf_if.sv
// Digest-in strobe and word-out valid/ready stream of the reorder buffer.
// master: producer/consumer side; slave: the reorder buffer itself.
interface sha_result_reorder_buf_if
  import sha_pkg::*;
#(
  parameter int TAG_WIDTH    = 14,
  parameter int DIGEST_WIDTH = SHA1_DIGEST_W,
  parameter int OUT_WIDTH    = 32
) ();

  logic                    in_valid;
  logic [TAG_WIDTH-1:0]    in_tag;
  logic [DIGEST_WIDTH-1:0] in_digest;

  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_WIDTH-1:0]    out_data;
  logic                    out_sop;
  logic                    out_eop;
  logic [TAG_WIDTH-1:0]    out_tag;

  modport master (
    output in_valid, in_tag, in_digest,
    output out_ready,
    input  out_valid, out_data,
    input  out_sop, out_eop, out_tag
  );

  modport slave (
    input  in_valid, in_tag, in_digest,
    input  out_ready,
    output out_valid, out_data,
    output out_sop, out_eop, out_tag
  );

endinterface

// File: rtl/sha_digest_serializer.sv
// Parallel-load digest, shift out MSW first with valid/ready, sop/eop.
// Ports: clear/load control, load_data in, ready in; valid/data/sop/eop/done out.
module sha_digest_serializer
  import sha_pkg::*;
#(
  parameter int DIGEST_WIDTH = SHA1_DIGEST_W,
  parameter int OUT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    load,
  input  logic [DIGEST_WIDTH-1:0] load_data,
  input  logic                    ready,
  output logic                    valid,
  output logic [OUT_WIDTH-1:0]    data,
  output logic                    sop,
  output logic                    eop,
  output logic                    done
);

  localparam int WORDS = words_per_digest(DIGEST_WIDTH, OUT_WIDTH);
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] LAST = KW'(WORDS - 1);

  logic [DIGEST_WIDTH-1:0] sreg;
  logic [KW-1:0]           k;
  logic                    fire;

  assign fire = valid & ready;
  assign data = sreg[DIGEST_WIDTH-1 -: OUT_WIDTH];
  assign sop  = valid & (k == '0);
  assign eop  = valid & (k == LAST);
  assign done = fire & (k == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      sreg  <= '0;
      k     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      k     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      sreg  <= load_data;
      k     <= '0;
    end else if (fire) begin
      sreg <= sreg << OUT_WIDTH;
      if (k == LAST) begin
        valid <= 1'b0;
        k     <= '0;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha_result_reorder_buf.sv
// Reorders tagged digests into tag sequence and streams them as words.
// Ports: bus (digest in / word out), flush, win_free credit, err pulses, drop_cnt.
module sha_result_reorder_buf
  import sha_pkg::*;
#(
  parameter int TAG_WIDTH    = 14,
  parameter int DEPTH        = 64,
  parameter int DIGEST_WIDTH = SHA1_DIGEST_W,
  parameter int OUT_WIDTH    = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sha_result_reorder_buf_if.slave  bus,
  input  logic                     flush,
  input  logic [TAG_WIDTH-1:0]     flush_tag,
  output logic [$clog2(DEPTH):0]   win_free,
  output logic                     err_oow,
  output logic                     err_dup,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);

  localparam int LW = $clog2(DEPTH);
  localparam int FW = LW + 1;
  localparam logic [TAG_WIDTH:0] DEPTH_T = (TAG_WIDTH+1)'(DEPTH);

  logic [TAG_WIDTH-1:0]    exp_tag;
  logic [TAG_WIDTH-1:0]    delta;
  logic [LW-1:0]           in_slot;
  logic [LW-1:0]           exp_slot;
  logic [DEPTH-1:0]        vld;
  logic [DIGEST_WIDTH-1:0] mem [DEPTH];
  logic [DIGEST_WIDTH-1:0] rd_data;
  logic                    in_win;
  logic                    acc;
  logic                    rej;
  logic                    rel;
  logic                    rd_en;
  logic                    load;
  logic                    ser_done;
  rob_state_e              state;
  rob_state_e              next_state;

  // Modular distance handles the tag wrap at 2^TAG_WIDTH.
  assign delta    = bus.in_tag - exp_tag;
  assign in_slot  = bus.in_tag[LW-1:0];
  assign exp_slot = exp_tag[LW-1:0];
  assign in_win   = {1'b0, delta} < DEPTH_T;
  assign acc      = bus.in_valid & ~flush & in_win & ~vld[in_slot];
  assign rej      = bus.in_valid & ~flush & ~acc;
  assign rel      = ser_done & ~flush;

  // exp_tag is stable for the whole packet, so it doubles as out_tag.
  assign bus.out_tag = exp_tag;

  always_ff @(posedge clk) begin
    if (acc) mem[in_slot] <= bus.in_digest;
    if (rd_en) rd_data <= mem[exp_slot];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= '0;
      exp_tag  <= '0;
      win_free <= FW'(DEPTH);
      err_oow  <= 1'b0;
      err_dup  <= 1'b0;
      drop_cnt <= '0;
      state    <= IDLE;
    end else begin
      state   <= next_state;
      err_oow <= rej & ~in_win;
      err_dup <= rej & in_win;
      if (rej && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (flush) begin
        vld      <= '0;
        win_free <= FW'(DEPTH);
        exp_tag  <= flush_tag;
      end else begin
        // A slot being released can never be written in the same cycle.
        if (acc) vld[in_slot] <= 1'b1;
        if (rel) begin
          vld[exp_slot] <= 1'b0;
          exp_tag       <= exp_tag + 1'b1;
        end
        win_free <= win_free - FW'(acc) + FW'(rel);
      end
    end
  end

  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (vld[exp_slot]) begin
          rd_en      = 1'b1;
          next_state = RD;
        end
      end
      RD: begin
        load       = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        if (ser_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  sha_digest_serializer #(
    .DIGEST_WIDTH (DIGEST_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (load),
    .load_data (rd_data),
    .ready     (bus.out_ready),
    .valid     (bus.out_valid),
    .data      (bus.out_data),
    .sop       (bus.out_sop),
    .eop       (bus.out_eop),
    .done      (ser_done)
  );

endmodule
